// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with thresholds, occupancy count, error pulses and reset-busy handshake
// Define SYNC_FIFO_FWFT_EN to build the first-word-fall-through read port.
module sync_fifo_ctrl #(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 8,
   parameter int AF_LEVEL     = 2**ADDR_W-1,
   parameter int AE_LEVEL     = 1,
   parameter int RST_BUSY_CYC = 4
) (
   input  logic              sys_clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] din,
   input  logic              rd_en,
   output logic [DATA_W-1:0] dout,
   output logic              valid,
   output logic              full,
   output logic              almost_full,
   output logic              empty,
   output logic              almost_empty,
   output logic [ADDR_W:0]   data_count,
   output logic              overflow,
   output logic              underflow,
   output logic              rst_busy
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {ST_RESET, ST_BUSY, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [3:0]        busy_cnt_q, busy_cnt_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              valid_q, valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              rst_busy_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              run, mem_full, mem_empty, wr_acc, rd_acc, mem_rd;
   logic [ADDR_W:0]   mem_count, count;
   logic signed [31:0] count_s;

   always_comb begin
      run       = (state_q == ST_RUN);
      mem_count = wr_ptr_q - rd_ptr_q;
      mem_full  = (mem_count == (ADDR_W+1)'(DEPTH));
      mem_empty = (mem_count == '0);
`ifdef SYNC_FIFO_FWFT_EN
      count     = mem_count + {{ADDR_W{1'b0}}, valid_q};
      empty     = !run || !valid_q;
`else
      count     = mem_count;
      empty     = !run || mem_empty;
`endif
      full      = !run || mem_full;
      // Signed compare so out-of-range thresholds are taken literally.
      count_s      = 32'(count);
      almost_full  = !run || (count_s >= AF_LEVEL);
      almost_empty = !run || (count_s <= AE_LEVEL);
   end

   always_comb begin
      state_d     = state_q;
      busy_cnt_d  = busy_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      dout_d      = dout_q;
      wr_acc      = run && wr_en && !full;
      rd_acc      = run && rd_en && !empty;
      overflow_d  = run && wr_en && full;
      underflow_d = run && rd_en && empty;
`ifdef SYNC_FIFO_FWFT_EN
      mem_rd      = run && !mem_empty && (!valid_q || rd_acc);
      valid_d     = mem_rd || (valid_q && !rd_acc);
`else
      mem_rd      = rd_acc;
      valid_d     = rd_acc;
`endif
      if (mem_rd) begin
         dout_d   = mem[rd_ptr_q[ADDR_W-1:0]];
         rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
      end
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
      end
      case (state_q)
         ST_RESET: begin
            state_d    = ST_BUSY;
            busy_cnt_d = '0;
         end
         ST_BUSY: begin
            if (busy_cnt_q == 4'(RST_BUSY_CYC-1)) begin
               state_d = ST_RUN;
            end else begin
               busy_cnt_d = busy_cnt_q + 4'd1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q     <= ST_RESET;
         busy_cnt_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         dout_q      <= '0;
         valid_q     <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rst_busy_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         busy_cnt_q  <= busy_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rst_busy_q  <= (state_d != ST_RUN);
      end
   end

   // Storage has no reset; the pointers alone define what is held.
   always_ff @(posedge sys_clk) begin
      if (!rst && wr_acc) begin
         mem[wr_ptr_q[ADDR_W-1:0]] <= din;
      end
   end

   assign dout       = dout_q;
   assign valid      = valid_q;
   assign data_count = count;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;
   assign rst_busy   = rst_busy_q;

endmodule
